alpha_trim_mean: RTL and testbench

Downstream stage of the parallel sorter in the modified alpha-trimmed mean filter. It latches the 25-pixel window when sorting starts and takes the rank-ordered index list when sorting finishes. It drops the TRIM smallest and TRIM largest samples and accumulates the rest, one per clock. It then outputs their mean as the filtered pixel.

---
 rtl/alpha_trim_mean.sv | 186 ++++++++++++++++++
 tb/tb_alpha_trim_mean.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alpha_trim_mean.sv
// alpha_trim_mean
// Back end of the modified alpha-trimmed mean filter. It latches the pixel
// window when the sorter starts, then takes the rank-ordered index list when
// the sorter finishes. It discards the TRIM smallest and TRIM largest samples,
// accumulates the remaining N samples one per clock, and divides by N.
//
// Optional build macro: ALPHA_MEAN_ROUND_EN
//   defined     -> mean rounded half-up: floor((2*sum + N) / (2*N))
//   not defined -> mean truncated:       floor(sum / N)
// Latency and interface are the same in both builds.

module alpha_trim_mean #(
    parameter int DN     = 25,
    parameter int DW     = 8,
    parameter int DW_SEQ = $clog2(DN),
    parameter int TRIM   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 win_valid,
    input  logic [DW*DN-1:0]     data_window,
    input  logic                 seq_valid,
    input  logic [DW_SEQ*DN-1:0] sequence_sorted,
    output logic                 in_ready,
    output logic [DW-1:0]        mean_out,
    output logic                 out_valid
);

    // Number of kept samples, sum width, and a one-bit-wider width that
    // holds the doubled sum used by the rounding divider.
    localparam int N  = DN - 2 * TRIM;
    localparam int SW = DW + $clog2(N + 1);
    localparam int NW = SW + 1;

    // First and last rank slots that contribute to the sum.
    localparam logic [DW_SEQ-1:0] K_FIRST = DW_SEQ'(TRIM);
    localparam logic [DW_SEQ-1:0] K_LAST  = DW_SEQ'(DN - 1 - TRIM);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_SEQ = 3'd1,
        ACCUM    = 3'd2,
        DIV      = 3'd3,
        OUT      = 3'd4
    } state_t;

    state_t                state;
    state_t                next_state;

    logic [DW*DN-1:0]      win_reg;
    logic [DW_SEQ*DN-1:0]  seq_reg;
    logic [SW-1:0]         sum;
    logic [DW_SEQ-1:0]     k;

    logic [DW_SEQ-1:0]     cur_index;
    logic [DW-1:0]         cur_sample;
    logic [NW-1:0]         numer;
    logic [DW-1:0]         mean_next;

    // Selects rank slot i from the registered index list. Slots outside the
    // window never occur in ACCUM, but an out-of-range k reads as zero.
    function automatic logic [DW_SEQ-1:0] pick_index(
        input logic [DW_SEQ*DN-1:0] seq,
        input logic [DW_SEQ-1:0]    i
    );
        pick_index = '0;
        for (int j = 0; j < DN; j++) begin
            if (i == DW_SEQ'(j)) begin
                pick_index = seq[j*DW_SEQ +: DW_SEQ];
            end
        end
    endfunction

    // Selects sample i from the registered window. A corrupt index from the
    // sorter (>= DN) contributes zero instead of reading past the window.
    function automatic logic [DW-1:0] pick_sample(
        input logic [DW*DN-1:0]  win,
        input logic [DW_SEQ-1:0] i
    );
        pick_sample = '0;
        for (int j = 0; j < DN; j++) begin
            if (i == DW_SEQ'(j)) begin
                pick_sample = win[j*DW +: DW];
            end
        end
    endfunction

    // State register; reset returns the block to IDLE immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; strobes outside their accepting state are ignored.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    next_state = WAIT_SEQ;
                end
            end
            WAIT_SEQ: begin
                if (seq_valid) begin
                    next_state = ACCUM;
                end
            end
            ACCUM: begin
                if (k == K_LAST) begin
                    next_state = DIV;
                end
            end
            DIV: begin
                next_state = OUT;
            end
            OUT: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Handshake outputs decoded straight from the state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == OUT);
    end

    // Sample addressed by the current rank slot during accumulation.
    always_comb begin
        cur_index  = pick_index(seq_reg, k);
        cur_sample = pick_sample(win_reg, cur_index);
    end

    // Constant-divisor mean of the accumulated sum.
    always_comb begin
`ifdef ALPHA_MEAN_ROUND_EN
        numer     = {sum, 1'b0} + NW'(N);
        mean_next = DW'(numer / NW'(2 * N));
`else
        numer     = {1'b0, sum};
        mean_next = DW'(numer / NW'(N));
`endif
    end

    // Datapath registers: window/sequence capture, accumulation and result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_reg  <= '0;
            seq_reg  <= '0;
            sum      <= '0;
            k        <= '0;
            mean_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        win_reg <= data_window;
                    end
                end
                WAIT_SEQ: begin
                    if (seq_valid) begin
                        seq_reg <= sequence_sorted;
                        sum     <= '0;
                        k       <= K_FIRST;
                    end
                end
                ACCUM: begin
                    sum <= sum + SW'(cur_sample);
                    k   <= k + DW_SEQ'(1);
                end
                DIV: begin
                    mean_out <= mean_next;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alpha_trim_mean.sv
// tb_alpha_trim_mean
// Directed and randomized transactions for alpha_trim_mean. Expected means
// come from fixed constants for the hand-built windows and from a reference
// model (explicit rank list -> trimmed sum -> mean) for random windows.
// Honours ALPHA_MEAN_ROUND_EN the same way the design does.

module tb_alpha_trim_mean;

    localparam int DN     = 25;
    localparam int DW     = 8;
    localparam int DW_SEQ = $clog2(DN);
    localparam int TRIM   = 4;
    localparam int N      = DN - 2 * TRIM;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 win_valid = 1'b0;
    logic [DW*DN-1:0]     data_window = '0;
    logic                 seq_valid = 1'b0;
    logic [DW_SEQ*DN-1:0] sequence_sorted = '0;
    logic                 in_ready;
    logic [DW-1:0]        mean_out;
    logic                 out_valid;

    int total = 0;
    int bad   = 0;

    int tw[DN];
    int ts[DN];

    alpha_trim_mean #(
        .DN(DN), .DW(DW), .DW_SEQ(DW_SEQ), .TRIM(TRIM)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .win_valid(win_valid),
        .data_window(data_window),
        .seq_valid(seq_valid),
        .sequence_sorted(sequence_sorted),
        .in_ready(in_ready),
        .mean_out(mean_out),
        .out_valid(out_valid)
    );

    // 100 MHz free-running clock
    always #5 clk = ~clk;

    // One comparison: counts it, and reports and counts a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: walk the rank list, skip TRIM at each end, average the rest.
    function automatic int modelMean();
        int s;
        s = 0;
        for (int r = TRIM; r < DN - TRIM; r++) s += tw[ts[r]];
`ifdef ALPHA_MEAN_ROUND_EN
        return (2 * s + N) / (2 * N);
`else
        return s / N;
`endif
    endfunction

    // Rank list = true ascending order of the window (stable insertion sort).
    task automatic sortSeq();
        int t;
        for (int i = 0; i < DN; i++) ts[i] = i;
        for (int i = 1; i < DN; i++) begin
            for (int j = i; j > 0 && tw[ts[j-1]] > tw[ts[j]]; j--) begin
                t = ts[j]; ts[j] = ts[j-1]; ts[j-1] = t;
            end
        end
    endtask

    // Rank list = arbitrary permutation; the block must follow it blindly.
    task automatic shuffleSeq();
        int t, r;
        for (int i = 0; i < DN; i++) ts[i] = i;
        for (int i = DN - 1; i > 0; i--) begin
            r = $urandom_range(i, 0);
            t = ts[i]; ts[i] = ts[r]; ts[r] = t;
        end
    endtask

    task automatic packInputs();
        int v, q;
        for (int i = 0; i < DN; i++) begin
            v = tw[i];
            q = ts[i];
            data_window[i*DW +: DW]             = v[DW-1:0];
            sequence_sorted[i*DW_SEQ +: DW_SEQ] = q[DW_SEQ-1:0];
        end
    endtask

    // Full transaction with latency, result and post-strobe checks.
    task automatic applyStimulus(input string tag, input int exp, input int gap);
        int cnt;
        int w;
        logic [DW-1:0] held;
        packInputs();
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        checkOutput({tag, " ready_before"}, 32'(in_ready), 32'd1);
        win_valid = 1'b1;
        @(negedge clk);
        win_valid = 1'b0;
        checkOutput({tag, " ready_low"}, 32'(in_ready), 32'd0);
        data_window = ~data_window;
        repeat (gap) @(negedge clk);
        seq_valid = 1'b1;
        @(negedge clk);
        seq_valid = 1'b0;
        sequence_sorted = ~sequence_sorted;
        cnt = 1;
        while (!out_valid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput({tag, " latency"}, 32'(cnt), 32'(N + 2));
        checkOutput({tag, " mean"}, 32'(mean_out), 32'(exp));
        checkOutput({tag, " ready_in_out"}, 32'(in_ready), 32'd0);
        held = mean_out;
        @(negedge clk);
        checkOutput({tag, " strobe_len"}, 32'(out_valid), 32'd0);
        checkOutput({tag, " ready_after"}, 32'(in_ready), 32'd1);
        checkOutput({tag, " mean_hold"}, 32'(mean_out), 32'(held));
    endtask

    initial begin
        int pulses;
        int first;
        int cnt;

        // reset state
        #1;
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset mean_out", 32'(mean_out), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // flat window
        for (int i = 0; i < DN; i++) tw[i] = 100;
        sortSeq();
        applyStimulus("flat", 100, 3);

        // ramp with identity order: kept 4..20, sum 204
        for (int i = 0; i < DN; i++) tw[i] = i;
        sortSeq();
        applyStimulus("ramp", 12, 2);

        // impulse rejection
        for (int i = 0; i < DN; i++) tw[i] = 50;
        tw[3] = 0; tw[17] = 0; tw[5] = 255; tw[20] = 255;
        sortSeq();
        applyStimulus("outlier", 50, 4);

        // rounding: sum 179 over 17
        for (int i = 0; i < 4; i++) tw[i] = 0;
        for (int i = 4; i < 20; i++) tw[i] = 10;
        tw[20] = 19;
        for (int i = 21; i < DN; i++) tw[i] = 255;
        shuffleSeq();
        for (int i = 0; i < DN; i++) ts[i] = i;
`ifdef ALPHA_MEAN_ROUND_EN
        applyStimulus("round", 11, 1);
`else
        applyStimulus("round", 10, 1);
`endif

        // sequencing: stray seq_valid in IDLE, simultaneous strobes,
        // second window during WAIT_SEQ
        for (int i = 0; i < DN; i++) tw[i] = i;
        sortSeq();
        packInputs();
        seq_valid = 1'b1;
        @(negedge clk);
        seq_valid = 1'b0;
        checkOutput("seq stray_idle ready", 32'(in_ready), 32'd1);
        win_valid = 1'b1;
        seq_valid = 1'b1;
        @(negedge clk);
        win_valid = 1'b0;
        seq_valid = 1'b0;
        checkOutput("seq accept ready_low", 32'(in_ready), 32'd0);
        for (int i = 0; i < DN; i++) data_window[i*DW +: DW] = 8'd200;
        @(negedge clk);
        win_valid = 1'b1;
        @(negedge clk);
        win_valid = 1'b0;
        checkOutput("seq second_win ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        seq_valid = 1'b1;
        @(negedge clk);
        seq_valid = 1'b0;
        pulses = 0;
        first = -1;
        cnt = 1;
        repeat (40) begin
            if (out_valid) begin
                pulses++;
                if (first < 0) begin
                    first = cnt;
                    checkOutput("seq mean", 32'(mean_out), 32'd12);
                end
            end
            @(negedge clk);
            cnt++;
        end
        checkOutput("seq pulses", 32'(pulses), 32'd1);
        checkOutput("seq latency", 32'(first), 32'(N + 2));

        // reset in the middle of ACCUM
        for (int i = 0; i < DN; i++) tw[i] = $urandom_range(255, 0);
        sortSeq();
        packInputs();
        win_valid = 1'b1;
        @(negedge clk);
        win_valid = 1'b0;
        @(negedge clk);
        seq_valid = 1'b1;
        @(negedge clk);
        seq_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst mean_out", 32'(mean_out), 32'd0);
        checkOutput("rst in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        checkOutput("rst no_strobe", 32'(pulses), 32'd0);
        checkOutput("rst mean_still0", 32'(mean_out), 32'd0);
        applyStimulus("post_rst", modelMean(), 2);

        // randomized windows, true order and arbitrary order alternately
        for (int t = 0; t < 10; t++) begin
            int lo, hi;
            lo = $urandom_range(200, 0);
            hi = $urandom_range(255, lo);
            for (int i = 0; i < DN; i++) tw[i] = $urandom_range(hi, lo);
            if (t % 2 == 0) sortSeq();
            else shuffleSeq();
            applyStimulus($sformatf("rand%0d", t), modelMean(), $urandom_range(5, 0));
        end

        $display("[TB] test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
